// File: rtl/uart_frame_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_frame_rx
// Summary  : 16x oversampled UART receiver with 3-sample majority vote, frame
//            and parity error flags and break handling. Optional parity stage
//            enabled by macro UART_RX_PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
module uart_frame_rx #(
   parameter int CLK_FREQ  = 50000000,
   parameter int DATA_W    = 8,
   parameter int STOP_BITS = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [2:0]        baud_set,
   input  logic              rs232_rx,
`ifdef UART_RX_PARITY_EN
   input  logic              parity_odd,
`endif
   output logic [DATA_W-1:0] rx_byte,
   output logic              rx_done,
   output logic              frame_err,
   output logic              parity_err,
   output logic              rx_busy
);

   localparam int c_div_9600   = CLK_FREQ / (9600 * 16);
   localparam int c_div_19200  = CLK_FREQ / (19200 * 16);
   localparam int c_div_38400  = CLK_FREQ / (38400 * 16);
   localparam int c_div_57600  = CLK_FREQ / (57600 * 16);
   localparam int c_div_115200 = CLK_FREQ / (115200 * 16);
   localparam int c_div_w      = $clog2(c_div_9600 + 1);

   localparam logic [2:0] c_st_idle      = 3'd0;
   localparam logic [2:0] c_st_start     = 3'd1;
   localparam logic [2:0] c_st_data      = 3'd2;
`ifdef UART_RX_PARITY_EN
   localparam logic [2:0] c_st_parity    = 3'd3;
`endif
   localparam logic [2:0] c_st_stop      = 3'd4;
   localparam logic [2:0] c_st_wait_idle = 3'd5;

   logic               r_rx_meta;
   logic               r_rx_sync;
   logic               r_rx_prev;
   logic               w_fall;
   logic               w_restart;

   logic [c_div_w-1:0] w_div_sel;
   logic [c_div_w-1:0] r_div;
   logic [c_div_w-1:0] r_div_cnt;
   logic               w_tick;
   logic [3:0]         r_phase;
   logic               r_s7;
   logic               r_s8;
   logic               w_vote;
   logic               w_vote_at;
   logic               w_bit_end;

   logic [2:0]         r_state;
   logic [3:0]         r_bit_cnt;
   logic [3:0]         r_hi_cnt;
   logic [DATA_W-1:0]  r_shift;
   logic               r_ferr;
   logic               w_ferr_now;
   logic               w_perr;

   logic [DATA_W-1:0]  r_rx_byte;
   logic               r_rx_done;
   logic               r_frame_err;
   logic               r_parity_err;
   logic               r_rx_busy;

`ifdef UART_RX_PARITY_EN
   logic               r_podd;
   logic               r_par_bit;
`endif

   assign rx_byte    = r_rx_byte;
   assign rx_done    = r_rx_done;
   assign frame_err  = r_frame_err;
   assign parity_err = r_parity_err;
   assign rx_busy    = r_rx_busy;

   // Line idles high, so the synchronizer resets to 1 to avoid a phantom edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rx_meta <= 1'b1;
         r_rx_sync <= 1'b1;
         r_rx_prev <= 1'b1;
      end else begin
         r_rx_meta <= rs232_rx;
         r_rx_sync <= r_rx_meta;
         r_rx_prev <= r_rx_sync;
      end
   end

   assign w_fall    = r_rx_prev & ~r_rx_sync;
   assign w_restart = (r_state == c_st_idle) && w_fall;

   always_comb begin
      w_div_sel = c_div_w'(c_div_9600);
      case (baud_set)
         3'd1:    w_div_sel = c_div_w'(c_div_19200);
         3'd2:    w_div_sel = c_div_w'(c_div_38400);
         3'd3:    w_div_sel = c_div_w'(c_div_57600);
         3'd4:    w_div_sel = c_div_w'(c_div_115200);
         default: w_div_sel = c_div_w'(c_div_9600);
      endcase
   end

   assign w_tick    = (r_div_cnt == (r_div - c_div_w'(1)));
   assign w_vote_at = w_tick && (r_phase == 4'd9);
   assign w_bit_end = w_tick && (r_phase == 4'd15);
   assign w_vote    = (r_s7 & r_s8) | (r_s7 & r_rx_sync) | (r_s8 & r_rx_sync);

   // Oversample divider and bit phase; both realign to the detected start edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_div     <= c_div_w'(c_div_9600);
         r_div_cnt <= '0;
         r_phase   <= '0;
         r_s7      <= 1'b1;
         r_s8      <= 1'b1;
      end else if (w_restart) begin
         r_div     <= w_div_sel;
         r_div_cnt <= '0;
         r_phase   <= '0;
      end else if (w_tick) begin
         r_div_cnt <= '0;
         r_phase   <= r_phase + 4'd1;
         if (r_phase == 4'd7) begin
            r_s7 <= r_rx_sync;
         end
         if (r_phase == 4'd8) begin
            r_s8 <= r_rx_sync;
         end
      end else begin
         r_div_cnt <= r_div_cnt + c_div_w'(1);
      end
   end

   assign w_ferr_now = r_ferr | ~w_vote;
`ifdef UART_RX_PARITY_EN
   assign w_perr = (^r_shift) ^ r_par_bit ^ r_podd;
`else
   assign w_perr = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= c_st_idle;
         r_bit_cnt    <= '0;
         r_hi_cnt     <= '0;
         r_shift      <= '0;
         r_ferr       <= 1'b0;
         r_rx_byte    <= '0;
         r_rx_done    <= 1'b0;
         r_frame_err  <= 1'b0;
         r_parity_err <= 1'b0;
         r_rx_busy    <= 1'b0;
`ifdef UART_RX_PARITY_EN
         r_podd       <= 1'b0;
         r_par_bit    <= 1'b0;
`endif
      end else begin
         r_rx_done <= 1'b0;
         case (r_state)
            c_st_idle: begin
               if (w_fall) begin
                  r_state <= c_st_start;
`ifdef UART_RX_PARITY_EN
                  r_podd  <= parity_odd;
`endif
               end
            end
            c_st_start: begin
               if (w_vote_at) begin
                  if (w_vote) begin
                     r_state <= c_st_idle;
                  end else begin
                     r_rx_busy <= 1'b1;
                  end
               end else if (w_bit_end) begin
                  r_state   <= c_st_data;
                  r_bit_cnt <= '0;
               end
            end
            c_st_data: begin
               if (w_vote_at) begin
                  r_shift <= {w_vote, r_shift[DATA_W-1:1]};
               end else if (w_bit_end) begin
                  if (r_bit_cnt == 4'(DATA_W - 1)) begin
                     r_bit_cnt <= '0;
                     r_ferr    <= 1'b0;
`ifdef UART_RX_PARITY_EN
                     r_state   <= c_st_parity;
`else
                     r_state   <= c_st_stop;
`endif
                  end else begin
                     r_bit_cnt <= r_bit_cnt + 4'd1;
                  end
               end
            end
`ifdef UART_RX_PARITY_EN
            c_st_parity: begin
               if (w_vote_at) begin
                  r_par_bit <= w_vote;
               end else if (w_bit_end) begin
                  r_state   <= c_st_stop;
                  r_bit_cnt <= '0;
                  r_ferr    <= 1'b0;
               end
            end
`endif
            // The frame closes at the last stop-bit vote rather than the bit end,
            // leaving slack to catch a back-to-back start edge from IDLE.
            c_st_stop: begin
               if (w_vote_at) begin
                  if (r_bit_cnt == 4'(STOP_BITS - 1)) begin
                     r_rx_byte    <= r_shift;
                     r_frame_err  <= w_ferr_now;
                     r_parity_err <= w_perr;
                     r_rx_done    <= 1'b1;
                     r_rx_busy    <= 1'b0;
                     r_hi_cnt     <= '0;
                     r_state      <= w_ferr_now ? c_st_wait_idle : c_st_idle;
                  end else begin
                     r_ferr <= w_ferr_now;
                  end
               end else if (w_bit_end) begin
                  r_bit_cnt <= r_bit_cnt + 4'd1;
               end
            end
            c_st_wait_idle: begin
               if (w_tick) begin
                  if (!r_rx_sync) begin
                     r_hi_cnt <= '0;
                  end else if (r_hi_cnt == 4'd15) begin
                     r_state <= c_st_idle;
                  end else begin
                     r_hi_cnt <= r_hi_cnt + 4'd1;
                  end
               end
            end
            default: begin
               r_state <= c_st_idle;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_uart_frame_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_frame_rx
// Summary  : Scoreboard bench for uart_frame_rx (8N1 and 7-bit/2-stop builds).
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_frame_rx;

   localparam int c_clk_freq = 3686400;

   typedef struct packed {
      logic       perr;
      logic       ferr;
      logic [8:0] data;
   } exp_t;

   logic       clk;
   logic       rst;
   logic [2:0] bs1;
   logic [2:0] bs2;
   logic       line1;
   logic       line2;
   logic [7:0] byte1;
   logic [6:0] byte2;
   logic       done1, done2, ferr1, ferr2, perr1, perr2, busy1, busy2;
`ifdef UART_RX_PARITY_EN
   logic       parity_odd;
`endif

   exp_t q1[$];
   exp_t q2[$];
   exp_t e1, e2;
   int   n_checks = 0;
   int   n_fail   = 0;
   int   ndone1   = 0;
   int   ndone2   = 0;
   logic prev1    = 1'b0;
   logic prev2    = 1'b0;

   uart_frame_rx #(.CLK_FREQ(c_clk_freq), .DATA_W(8), .STOP_BITS(1)) dut1 (
      .clk(clk), .rst(rst), .baud_set(bs1), .rs232_rx(line1),
`ifdef UART_RX_PARITY_EN
      .parity_odd(parity_odd),
`endif
      .rx_byte(byte1), .rx_done(done1), .frame_err(ferr1),
      .parity_err(perr1), .rx_busy(busy1)
   );

   uart_frame_rx #(.CLK_FREQ(c_clk_freq), .DATA_W(7), .STOP_BITS(2)) dut2 (
      .clk(clk), .rst(rst), .baud_set(bs2), .rs232_rx(line2),
`ifdef UART_RX_PARITY_EN
      .parity_odd(parity_odd),
`endif
      .rx_byte(byte2), .rx_done(done2), .frame_err(ferr2),
      .parity_err(perr2), .rx_busy(busy2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Scoreboard: each rx_done pops one expected frame; pulse must last one cycle.
   always @(negedge clk) begin
      if (prev1) begin
         n_checks++;
         if (done1 !== 1'b0) begin
            n_fail++;
            $display("FAIL dut1_done_width: rx_done=%b, expected 0 one cycle after pulse", done1);
         end
      end
      if (done1 === 1'b1) begin
         ndone1++;
         n_checks++;
         if (q1.size() == 0) begin
            n_fail++;
            $display("FAIL dut1_unexpected_done: rx_byte=%h, expected no frame", byte1);
         end else begin
            e1 = q1.pop_front();
            if ({perr1, ferr1, byte1} !== {e1.perr, e1.ferr, e1.data[7:0]}) begin
               n_fail++;
               $display("FAIL dut1_frame: rx_byte=%h ferr=%b perr=%b, expected rx_byte=%h ferr=%b perr=%b",
                        byte1, ferr1, perr1, e1.data[7:0], e1.ferr, e1.perr);
            end
         end
      end
      prev1 = (done1 === 1'b1);
   end

   always @(negedge clk) begin
      if (prev2) begin
         n_checks++;
         if (done2 !== 1'b0) begin
            n_fail++;
            $display("FAIL dut2_done_width: rx_done=%b, expected 0 one cycle after pulse", done2);
         end
      end
      if (done2 === 1'b1) begin
         ndone2++;
         n_checks++;
         if (q2.size() == 0) begin
            n_fail++;
            $display("FAIL dut2_unexpected_done: rx_byte=%h, expected no frame", byte2);
         end else begin
            e2 = q2.pop_front();
            if ({perr2, ferr2, byte2} !== {e2.perr, e2.ferr, e2.data[6:0]}) begin
               n_fail++;
               $display("FAIL dut2_frame: rx_byte=%h ferr=%b perr=%b, expected rx_byte=%h ferr=%b perr=%b",
                        byte2, ferr2, perr2, e2.data[6:0], e2.ferr, e2.perr);
            end
         end
      end
      prev2 = (done2 === 1'b1);
   end

   initial begin
      repeat (80000) @(posedge clk);
      $display("FAIL watchdog: simulation exceeded 80000 cycles, expected completion");
      $fatal(1, "watchdog expired");
   end

   function automatic int bclk(input logic [2:0] bs);
      int baud;
      case (bs)
         3'd1:    baud = 19200;
         3'd2:    baud = 38400;
         3'd3:    baud = 57600;
         3'd4:    baud = 115200;
         default: baud = 9600;
      endcase
      return (c_clk_freq / (baud * 16)) * 16;
   endfunction

   task automatic drive_bit(input int which, input logic v, input int n);
      if (which == 0) line1 = v;
      else            line2 = v;
      repeat (n) @(negedge clk);
   endtask

   task automatic send_frame(input int which, input logic [8:0] data, input int nbits,
                             input int nstop, input logic stop_val, input logic par_inv,
                             input int b);
      logic p;
      p = par_inv;
      drive_bit(which, 1'b0, b);
      for (int i = 0; i < nbits; i++) begin
         drive_bit(which, data[i], b);
         p = p ^ data[i];
      end
`ifdef UART_RX_PARITY_EN
      drive_bit(which, p ^ parity_odd, b);
`endif
      for (int i = 0; i < nstop; i++) drive_bit(which, stop_val, b);
   endtask

   task automatic expect_frame(input int which, input logic [8:0] data, input logic ferr,
                               input logic par_inv);
      exp_t e;
      e.data = data;
      e.ferr = ferr;
`ifdef UART_RX_PARITY_EN
      e.perr = par_inv;
`else
      e.perr = 1'b0;
`endif
      if (which == 0) q1.push_back(e);
      else            q2.push_back(e);
   endtask

   task automatic wait_drain(input int max_cycles);
      for (int i = 0; i < max_cycles; i++) begin
         if (q1.size() == 0 && q2.size() == 0) break;
         @(negedge clk);
      end
      repeat (4) @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (5) @(negedge clk);
      n_checks += 2;
      if ({byte1, done1, ferr1, perr1, busy1} !== 12'h000) begin
         n_fail++;
         $display("FAIL reset_dut1: outputs=%h, expected 000", {byte1, done1, ferr1, perr1, busy1});
      end
      if ({byte2, done2, ferr2, perr2, busy2} !== 11'h000) begin
         n_fail++;
         $display("FAIL reset_dut2: outputs=%h, expected 000", {byte2, done2, ferr2, perr2, busy2});
      end
      rst = 1'b0;
      repeat (5) @(negedge clk);
   endtask

   task automatic test_basic();
      int b;
      int d0;
      b  = bclk(3'd1);
      d0 = ndone1;
      expect_frame(0, 9'h0AA, 1'b0, 1'b0);
      expect_frame(0, 9'h055, 1'b0, 1'b0);
      fork
         begin
            send_frame(0, 9'h0AA, 8, 1, 1'b1, 1'b0, b);
            send_frame(0, 9'h055, 8, 1, 1'b1, 1'b0, b);
         end
         begin
            repeat (3 * b) @(negedge clk);
            n_checks++;
            if (busy1 !== 1'b1) begin
               n_fail++;
               $display("FAIL basic_busy_mid: rx_busy=%b, expected 1", busy1);
            end
         end
      join
      drive_bit(0, 1'b1, b);
      wait_drain(4 * b);
      n_checks += 3;
      if (ndone1 - d0 !== 2) begin
         n_fail++;
         $display("FAIL basic_done_count: got %0d pulses, expected 2", ndone1 - d0);
      end
      if (busy1 !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_busy_idle: rx_busy=%b, expected 0", busy1);
      end
      if (byte1 !== 8'h55) begin
         n_fail++;
         $display("FAIL basic_hold: rx_byte=%h, expected 55", byte1);
      end
   endtask

   task automatic test_glitch();
      int b;
      int d0;
      b  = bclk(3'd1);
      d0 = ndone1;
      drive_bit(0, 1'b0, 4 * (b / 16));
      drive_bit(0, 1'b1, 2 * b);
      n_checks += 2;
      if (ndone1 !== d0) begin
         n_fail++;
         $display("FAIL glitch_no_done: got %0d pulses, expected 0", ndone1 - d0);
      end
      if (busy1 !== 1'b0) begin
         n_fail++;
         $display("FAIL glitch_busy: rx_busy=%b, expected 0", busy1);
      end
      expect_frame(0, 9'h03C, 1'b0, 1'b0);
      send_frame(0, 9'h03C, 8, 1, 1'b1, 1'b0, b);
      drive_bit(0, 1'b1, b);
      wait_drain(4 * b);
      n_checks++;
      if (q1.size() !== 0) begin
         n_fail++;
         $display("FAIL glitch_next_frame: %0d frames pending, expected 0", q1.size());
      end
   endtask

   task automatic test_frame_err();
      int b;
      int d0;
      b  = bclk(3'd1);
      d0 = ndone1;
      expect_frame(0, 9'h081, 1'b1, 1'b0);
      send_frame(0, 9'h081, 8, 1, 1'b0, 1'b0, b);
      drive_bit(0, 1'b0, 2 * b);
      drive_bit(0, 1'b1, b / 2);
      // Still in break recovery: this frame must be ignored.
      send_frame(0, 9'h000, 8, 1, 1'b1, 1'b0, b);
      drive_bit(0, 1'b1, b);
      n_checks++;
      if (ndone1 - d0 !== 1) begin
         n_fail++;
         $display("FAIL ferr_break_ignored: got %0d pulses, expected 1", ndone1 - d0);
      end
      expect_frame(0, 9'h05A, 1'b0, 1'b0);
      send_frame(0, 9'h05A, 8, 1, 1'b1, 1'b0, b);
      drive_bit(0, 1'b1, b);
      wait_drain(4 * b);
      n_checks++;
      if (ndone1 - d0 !== 2) begin
         n_fail++;
         $display("FAIL ferr_recover: got %0d pulses, expected 2", ndone1 - d0);
      end
   endtask

`ifdef UART_RX_PARITY_EN
   task automatic test_parity();
      int b;
      b = bclk(3'd1);
      parity_odd = 1'b0;
      expect_frame(0, 9'h007, 1'b0, 1'b0);
      send_frame(0, 9'h007, 8, 1, 1'b1, 1'b0, b);
      expect_frame(0, 9'h007, 1'b0, 1'b1);
      send_frame(0, 9'h007, 8, 1, 1'b1, 1'b1, b);
      parity_odd = 1'b1;
      expect_frame(0, 9'h007, 1'b0, 1'b0);
      send_frame(0, 9'h007, 8, 1, 1'b1, 1'b0, b);
      drive_bit(0, 1'b1, b);
      wait_drain(4 * b);
      parity_odd = 1'b0;
      n_checks++;
      if (q1.size() !== 0) begin
         n_fail++;
         $display("FAIL parity_pending: %0d frames pending, expected 0", q1.size());
      end
   endtask
`endif

   task automatic test_back_to_back();
      int b;
      int d0;
      bs2 = 3'd4;
      b   = bclk(3'd4);
      d0  = ndone2;
      expect_frame(1, 9'h05A, 1'b0, 1'b0);
      expect_frame(1, 9'h025, 1'b0, 1'b0);
      fork
         begin
            send_frame(1, 9'h05A, 7, 2, 1'b1, 1'b0, b);
            send_frame(1, 9'h025, 7, 2, 1'b1, 1'b0, b);
         end
         begin
            repeat (100) @(negedge clk);
            bs2 = 3'd0;
            repeat (100) @(negedge clk);
            bs2 = 3'd4;
            repeat (220) @(negedge clk);
            bs2 = 3'd1;
            repeat (100) @(negedge clk);
            bs2 = 3'd4;
         end
      join
      drive_bit(1, 1'b1, b);
      wait_drain(8 * b);
      n_checks++;
      if (ndone2 - d0 !== 2) begin
         n_fail++;
         $display("FAIL b2b_done_count: got %0d pulses, expected 2", ndone2 - d0);
      end
   endtask

   task automatic test_reset_mid_frame();
      int b;
      int d0;
      b  = bclk(3'd1);
      d0 = ndone1;
      fork
         send_frame(0, 9'h0F0, 8, 1, 1'b1, 1'b1, b);
         begin
            repeat (4 * b + b / 4) @(negedge clk);
            rst = 1'b1;
            repeat (3) @(negedge clk);
            n_checks++;
            if ({byte1, done1, ferr1, perr1, busy1} !== 12'h000) begin
               n_fail++;
               $display("FAIL rst_mid_outputs: outputs=%h, expected 000",
                        {byte1, done1, ferr1, perr1, busy1});
            end
            repeat (b) @(negedge clk);
            rst = 1'b0;
         end
      join
      drive_bit(0, 1'b1, b);
      n_checks += 2;
      if (ndone1 !== d0) begin
         n_fail++;
         $display("FAIL rst_mid_no_done: got %0d pulses, expected 0", ndone1 - d0);
      end
      if (byte1 !== 8'h00) begin
         n_fail++;
         $display("FAIL rst_mid_byte: rx_byte=%h, expected 00", byte1);
      end
      expect_frame(0, 9'h00F, 1'b0, 1'b0);
      send_frame(0, 9'h00F, 8, 1, 1'b1, 1'b0, b);
      drive_bit(0, 1'b1, b);
      wait_drain(4 * b);
      n_checks++;
      if (ndone1 - d0 !== 1) begin
         n_fail++;
         $display("FAIL rst_mid_resume: got %0d pulses, expected 1", ndone1 - d0);
      end
   endtask

   initial begin
      line1 = 1'b1;
      line2 = 1'b1;
      bs1   = 3'd1;
      bs2   = 3'd4;
      rst   = 1'b1;
`ifdef UART_RX_PARITY_EN
      parity_odd = 1'b0;
`endif
      test_reset();
      test_basic();
      test_glitch();
      test_frame_err();
`ifdef UART_RX_PARITY_EN
      test_parity();
`endif
      test_back_to_back();
      test_reset_mid_frame();
      n_checks++;
      if (q1.size() + q2.size() !== 0) begin
         n_fail++;
         $display("FAIL final_queues: %0d frames pending, expected 0", q1.size() + q2.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
